// File: rtl/mul_div_divider.sv
// Iterative radix-2 restoring divider for MIPS32 DIV/DIVU (LO = quotient, HI = remainder).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle on divide-by-zero or |dividend| < |divisor|.
module mul_div_divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  input  logic        abort,
  input  logic        hold,
  output logic        div_ready,
  output logic [31:0] div_lo,
  output logic [31:0] div_hi
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    rem, quo, dsr;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg;
  logic            load, finish;

  // Operand magnitudes and signs at the start request
  logic            s1, s2;
  logic [W-1:0]    mag1, mag2;

  assign s1   = div_signed & opr1[W-1];
  assign s2   = div_signed & opr2[W-1];
  assign mag1 = s1 ? W'(0) - opr1 : opr1;
  assign mag2 = s2 ? W'(0) - opr2 : opr2;

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor
  logic [W:0]      shifted;
  logic [W-1:0]    diff, r_nxt, q_nxt, lo_fin, hi_fin;
  logic            qbit;

  assign shifted = {rem, quo[W-1]};
  assign qbit    = (shifted >= {1'b0, dsr});
  assign diff    = W'(shifted - {1'b0, dsr});
  assign r_nxt   = qbit ? diff : shifted[W-1:0];
  assign q_nxt   = {quo[W-2:0], qbit};
  assign lo_fin  = q_neg ? W'(0) - q_nxt : q_nxt;
  assign hi_fin  = r_neg ? W'(0) - r_nxt : r_nxt;

`ifdef DIV_EARLY_OUT_EN
  logic            early;
  logic [W-1:0]    early_q, early_lo;

  assign early_q  = (mag2 == '0) ? '1 : '0;
  assign early_lo = (s1 ^ s2) ? W'(0) - early_q : early_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (div_start && !abort) begin
          load       = 1'b1;
          state_next = DIV;
`ifdef DIV_EARLY_OUT_EN
          if (mag2 == '0 || mag1 < mag2) begin
            early      = 1'b1;
            state_next = DONE;
          end
`endif
        end
      end
      DIV: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt == CW'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (abort || !hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem       <= '0;
      quo       <= '0;
      dsr       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_ready <= 1'b0;
      div_lo    <= '0;
      div_hi    <= '0;
    end else begin
      if (load) begin
        rem   <= '0;
        quo   <= mag1;
        dsr   <= mag2;
        cnt   <= CW'(W);
        q_neg <= s1 ^ s2;
        r_neg <= s1;
      end else if (state == DIV && !abort) begin
        rem <= r_nxt;
        quo <= q_nxt;
        cnt <= cnt - CW'(1);
      end
      // Sign fix lands with the last iteration so the results are registered
      if (finish) begin
        div_lo <= lo_fin;
        div_hi <= hi_fin;
      end
`ifdef DIV_EARLY_OUT_EN
      if (early) begin
        div_lo <= early_lo;
        div_hi <= opr1;
      end
`endif
      div_ready <= (state_next == DONE);
    end
  end

endmodule

// File: doc/mul_div_divider.md
# mul_div_divider

Iterative radix-2 restoring divider for MIPS32 DIV/DIVU. It is the EX-stage companion of the ALU, which drives `div_start`/`div_signed` and the operands and holds the pipeline via stall request until `div_ready`. The quotient and remainder go to the HI/LO write path at the end of EX: LO gets the quotient, HI gets the remainder.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  core clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `div_start`  in  1  request; ALU holds it high (= !div_ready) while a DIV/DIVU sits in EX
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- `opr1`  in  32  dividend; sampled with start
- `opr2`  in  32  divisor; sampled with start
- `abort`  in  1  pipeline flush (exception/ERET); kills any operation
- `hold`  in  1  downstream stall; keeps DONE asserted
- `div_ready`  out  1  result valid
- `div_lo`  out  32  quotient
- `div_hi`  out  32  remainder

## Operation
- FSM states: IDLE, DIV, DONE.
- **IDLE:**
  - If `div_start && !abort`, latch the operands.
  - Convert to magnitudes when signed.
  - Record `q_neg = s1^s2` and `r_neg = s1`.
  - Clear the 33-bit partial remainder, set the 6-bit counter = 32, go to DIV.
- **DIV:**
  - Each cycle shift {rem, dividend} left 1 bit and trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; after the 32nd iteration go to DONE.
- **DONE:**
  - `div_ready = 1`.
  - `div_lo` is the quotient, negated if `q_neg`; `div_hi` is the remainder, negated if `r_neg`.
  - Sign fix is applied on the DIV→DONE edge, so outputs are registered.
  - Next state is IDLE unless `hold` = 1, in which case stay in DONE.
- `div_hi`/`div_lo` keep their last result through IDLE until the next DONE overwrites them.
- **Boundary cases:**
  - `div_start` in DIV or DONE is ignored; there is no restart.
  - `abort` in any state: next state IDLE, `div_ready` = 0 next cycle, result registers unchanged.
  - `abort` together with start in IDLE: abort wins, nothing latched.
  - Reset mid-operation: immediate IDLE, all outputs cleared.
  - Divide by zero: quotient 0xFFFFFFFF and remainder = dividend, before sign fix. This is the natural restoring result.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; no exception.
  - Signed remainder takes the sign of the dividend; quotient truncates toward zero.

## Timing
- Reset values: `div_ready` 0, `div_lo` 0, `div_hi` 0, state IDLE, counter 0.
- Start sampled high in IDLE at cycle N:
  - DIV occupies cycles N+1..N+32.
  - `div_ready` = 1 in cycle N+33.
  - ALU `div_start` falls combinationally in N+33 and EX advances.
- Total EX occupancy is 34 cycles.
- `div_ready` is a one-cycle pulse when `hold` = 0; it stays high while `hold` = 1 and drops the cycle after `hold` falls.
- Back-to-back divides: a new start is accepted in the first IDLE cycle after DONE.

## Configuration
- Macro `DIV_EARLY_OUT_EN`:
  - **Defined:** in IDLE on an accepted start, if divisor = 0 or |dividend| < |divisor|, go straight to DONE.
    - Divisor = 0: quotient 0xFFFFFFFF, remainder = dividend.
    - |dividend| < |divisor|: quotient 0, remainder = dividend, sign rules unchanged.
    - `div_ready` in N+1.
  - **Undefined:** every divide takes the full 33-cycle latency with identical numerical results.

## Test plan
- DIVU 100 / 7 → `div_ready` at N+33, `div_lo` = 14, `div_hi` = 2; `div_ready` low at N+34.
- DIV −7 / 2 (0xFFFFFFF9, 2) → `div_lo` = 0xFFFFFFFD (−3), `div_hi` = 0xFFFFFFFF (−1). DIV 7 / −2 → `div_lo` = 0xFFFFFFFD, `div_hi` = 1.
- DIV 0x80000000 / 0xFFFFFFFF → `div_lo` = 0x80000000, `div_hi` = 0. DIVU 5 / 0:
  - without the macro → `div_lo` = 0xFFFFFFFF, `div_hi` = 5 at N+33;
  - with `DIV_EARLY_OUT_EN` → same values at N+1.
- `abort` at N+10 → state IDLE at N+11, no `div_ready` pulse, `div_hi`/`div_lo` retain previous values. A new start at N+11 completes at N+44.
- `hold` = 1 for cycles N+33..N+35 → `div_ready` high N+33..N+36, low at N+37. Start toggled during DIV has no effect.
- Drop `resetn` at N+20 → all outputs 0 immediately; divide 1 / 1 after release gives `div_lo` = 1, `div_hi` = 0.
